// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - frame byte stream and RAM bus signals of the RAM loader
interface ram_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    // master is the host/RAM side, slave is the loader
    modport master (
        output in_valid, in_data, ram_data,
        input  in_ready, ram_address, ram_write, ram_write_data, busy, done, error
    );

    modport slave (
        input  in_valid, in_data, ram_data,
        output in_ready, ram_address, ram_write, ram_write_data, busy, done, error
    );
endinterface

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - loads a framed byte stream (addr, len, payload, checksum) into RAM with read-back verify
module ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic  clock,
    input  logic  reset,
    ram_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        VERIFY,
        CSUM
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  in_ready;
    logic                  ram_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            sum_q         <= '0;
            byte_q        <= '0;
            ram_address_q <= '0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            byte_q        <= byte_d;
            ram_address_q <= ram_address_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        sum_d         = sum_q;
        byte_d        = byte_q;
        ram_address_d = ram_address_q;
        wdata_d       = wdata_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        in_ready      = 1'b0;
        ram_write     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    addr_d  = ADDR_WIDTH'(bus.in_data);
                    sum_d   = bus.in_data;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEN;
                end
            end
            LEN: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    count_d = bus.in_data;
                    sum_d   = sum_q + bus.in_data;
                    state_d = (bus.in_data == '0) ? CSUM : DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    byte_d        = bus.in_data;
                    sum_d         = sum_q + bus.in_data;
                    // the RAM-facing registers are only loaded here so they hold while idle
                    ram_address_d = addr_q;
                    wdata_d       = bus.in_data;
                    state_d       = WRITE;
                end
            end
            WRITE: begin
                ram_write = 1'b1;
                state_d   = VERIFY;
            end
            VERIFY: begin
                if (bus.ram_data != byte_q) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    state_d = (count_q == DATA_WIDTH'(1)) ? CSUM : DATA;
                end
            end
            CSUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready       = in_ready;
    assign bus.ram_write      = ram_write;
    assign bus.ram_address    = ram_address_q;
    assign bus.ram_write_data = wdata_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
endmodule
